// File: rtl/i2s_adc_receiver_pkg.sv
// Shared types and defaults for the I2S ADC receive path.
package i2s_adc_receiver_pkg;

   localparam int WIDTH_DEFAULT       = 16;
   localparam int SYNC_STAGES_DEFAULT = 2;

   typedef enum logic [1:0] {
      ST_ALIGN = 2'd0,
      ST_DELAY = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } rx_state_t;

   typedef enum logic {
      CH_L = 1'b0,
      CH_R = 1'b1
   } channel_t;

   function automatic logic is_falling(input logic prev, input logic cur);
      return prev & ~cur;
   endfunction

endpackage

// File: rtl/i2s_adc_receiver_sync_edge.sv
// Brings bclk and its companion serial lines into the clk domain; flags sync'd bclk rises.
module i2s_adc_receiver_sync_edge
   import i2s_adc_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int DATA_BITS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 edge_in,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 edge_rise,
   output logic [DATA_BITS-1:0] data_out
);

   logic [SYNC_STAGES-1:0] edge_sync_reg;
   logic                   edge_prev_reg;
   logic [SYNC_STAGES-1:0] data_sync_reg [DATA_BITS];

   always_ff @(posedge clk) begin
      if (!reset) begin
         edge_sync_reg <= '0;
         edge_prev_reg <= 1'b0;
      end else begin
         edge_sync_reg <= {edge_sync_reg[SYNC_STAGES-2:0], edge_in};
         edge_prev_reg <= edge_sync_reg[SYNC_STAGES-1];
      end
   end

   assign edge_rise = edge_sync_reg[SYNC_STAGES-1] & ~edge_prev_reg;

   // Data lanes share the same depth so they stay aligned with the bclk rise flag.
   generate
      for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (!reset) begin
               data_sync_reg[gi] <= '0;
            end else begin
               data_sync_reg[gi] <= {data_sync_reg[gi][SYNC_STAGES-2:0], data_in[gi]};
            end
         end
         assign data_out[gi] = data_sync_reg[gi][SYNC_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/i2s_adc_receiver.sv
// Deserialises I2S ADC data into stereo frames in the CLOCK_50 domain with a valid/ready output.
module i2s_adc_receiver
   import i2s_adc_receiver_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bclk,
   input  logic             adclrck,
   input  logic             adcdat,
   output logic [WIDTH-1:0] left_sample,
   output logic [WIDTH-1:0] right_sample,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overrun,
   output logic             frame_error
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             bclk_rise;
   logic             lrck_s;
   logic             dat_s;

   rx_state_t        state_reg;
   channel_t         ch_reg;
   logic [CNT_W-1:0] bit_cnt_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] left_capt_reg;
   logic             left_ok_reg;
   logic             lrck_prev_reg;
   logic             frame_error_reg;

   logic [WIDTH-1:0] left_sample_reg;
   logic [WIDTH-1:0] right_sample_reg;
   logic             valid_reg;
   logic             overrun_reg;

   logic             lrck_edge;
   logic             lrck_fall;
   logic             last_bit;
   logic             frame_done;
   logic [WIDTH-1:0] shift_next;

   i2s_adc_receiver_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .DATA_BITS   (2)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .edge_in   (bclk),
      .data_in   ({adcdat, adclrck}),
      .edge_rise (bclk_rise),
      .data_out  ({dat_s, lrck_s})
   );

   always_comb begin
      lrck_edge  = bclk_rise && (lrck_s != lrck_prev_reg);
      lrck_fall  = bclk_rise && is_falling(lrck_prev_reg, lrck_s);
      shift_next = {shift_reg[WIDTH-2:0], dat_s};
      last_bit   = (bit_cnt_reg == CNT_W'(WIDTH - 1));
      frame_done = bclk_rise && (state_reg == ST_SHIFT) && !lrck_edge && last_bit &&
                   (ch_reg == CH_R) && left_ok_reg;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= ST_ALIGN;
         ch_reg          <= CH_L;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         left_capt_reg   <= '0;
         left_ok_reg     <= 1'b0;
         lrck_prev_reg   <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         frame_error_reg <= 1'b0;
         if (bclk_rise) begin
            lrck_prev_reg <= lrck_s;
            case (state_reg)
               ST_ALIGN: begin
                  if (lrck_fall) begin
                     state_reg   <= ST_DELAY;
                     ch_reg      <= CH_L;
                     left_ok_reg <= 1'b0;
                  end
               end
               ST_DELAY: begin
                  // Any abort also voids a pending left, so a cut-short left drops its right too.
                  if (lrck_edge) begin
                     frame_error_reg <= 1'b1;
                     ch_reg          <= channel_t'(lrck_s);
                     left_ok_reg     <= 1'b0;
                  end else begin
                     state_reg   <= ST_SHIFT;
                     bit_cnt_reg <= '0;
                     shift_reg   <= '0;
                  end
               end
               ST_SHIFT: begin
                  if (lrck_edge) begin
                     frame_error_reg <= 1'b1;
                     state_reg       <= ST_DELAY;
                     ch_reg          <= channel_t'(lrck_s);
                     left_ok_reg     <= 1'b0;
                  end else begin
                     shift_reg <= shift_next;
                     if (last_bit) begin
                        state_reg <= ST_HOLD;
                        if (ch_reg == CH_L) begin
                           left_capt_reg <= shift_next;
                           left_ok_reg   <= 1'b1;
                        end else begin
                           left_ok_reg <= 1'b0;
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                     end
                  end
               end
               ST_HOLD: begin
                  if (lrck_edge) begin
                     state_reg <= ST_DELAY;
                     ch_reg    <= channel_t'(lrck_s);
                     if (!lrck_s) begin
                        left_ok_reg <= 1'b0;
                     end
                  end
               end
               default: state_reg <= ST_ALIGN;
            endcase
         end
      end
   end

   // A completed frame lands only if the output slot is empty or being emptied this cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         left_sample_reg  <= '0;
         right_sample_reg <= '0;
         valid_reg        <= 1'b0;
         overrun_reg      <= 1'b0;
      end else begin
         if (frame_done) begin
            if (!valid_reg || sample_ready) begin
               left_sample_reg  <= left_capt_reg;
               right_sample_reg <= shift_next;
               valid_reg        <= 1'b1;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (valid_reg && sample_ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign left_sample  = left_sample_reg;
   assign right_sample = right_sample_reg;
   assign sample_valid = valid_reg;
   assign overrun      = overrun_reg;
   assign frame_error  = frame_error_reg;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench: drives an I2S ADC bit stream at clk/16 and checks frames, handshake and errors.
module tb_i2s_adc_receiver;

   localparam int WIDTH = 16;
   localparam int SLOT  = 20;   // bclk rises per channel: edge, delay, 16 data, 2 pad

   logic             clk;
   logic             reset;
   logic             bclk;
   logic             adclrck;
   logic             adcdat;
   logic [WIDTH-1:0] left_sample;
   logic [WIDTH-1:0] right_sample;
   logic             sample_valid;
   logic             sample_ready;
   logic             overrun;
   logic             frame_error;

   int checks   = 0;
   int failures = 0;

   int               valid_cycles     = 0;
   int               valid_low_cycles = 0;
   int               err_cycles       = 0;
   int               acc_cnt          = 0;
   logic [WIDTH-1:0] acc_l            = '0;
   logic [WIDTH-1:0] acc_r            = '0;

   i2s_adc_receiver #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bclk         (bclk),
      .adclrck      (adclrck),
      .adcdat       (adcdat),
      .left_sample  (left_sample),
      .right_sample (right_sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .frame_error  (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observes the handshake just after the negedge when inputs are already set for the next rise.
   always @(negedge clk) begin
      #1;
      if (reset) begin
         if (sample_valid) valid_cycles++;
         else valid_low_cycles++;
         if (frame_error) err_cycles++;
         if (sample_valid && sample_ready) begin
            acc_cnt++;
            acc_l = left_sample;
            acc_r = right_sample;
         end
      end
   end

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bit_cycle(input logic lr, input logic dat, input logic ready_pulse);
      bclk    = 1'b0;
      adclrck = lr;
      adcdat  = dat;
      repeat (8) @(negedge clk);
      bclk = 1'b1;
      if (ready_pulse) begin
         repeat (2) @(negedge clk);
         sample_ready = 1'b1;
         @(negedge clk);
         sample_ready = 1'b0;
         repeat (5) @(negedge clk);
      end else begin
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic send_slot(input logic lr, input logic [WIDTH-1:0] word, input int nbits,
                            input logic pulse_last);
      for (int j = 0; j < nbits; j++) begin
         logic d;
         d = (j >= 2 && j <= 17) ? word[17 - j] : 1'b0;
         bit_cycle(lr, d, pulse_last && (j == 17));
      end
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                             input logic pulse_last);
      send_slot(1'b0, l, SLOT, 1'b0);
      send_slot(1'b1, r, SLOT, pulse_last);
   endtask

   task automatic consume();
      sample_ready = 1'b1;
      repeat (2) @(negedge clk);
      sample_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int v0, a0, l0, e0;
      reset        = 1'b0;
      bclk         = 1'b0;
      adclrck      = 1'b1;
      adcdat       = 1'b0;
      sample_ready = 1'b0;

      // 1: reset with bclk toggling, then no frame before a left start
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         bclk = ~bclk;
      end
      expect_eq("rst_left",   32'(left_sample),  32'h0);
      expect_eq("rst_right",  32'(right_sample), 32'h0);
      expect_eq("rst_valid",  32'(sample_valid), 32'h0);
      expect_eq("rst_overrun",32'(overrun),      32'h0);
      expect_eq("rst_ferr",   32'(frame_error),  32'h0);
      reset = 1'b1;
      v0 = valid_cycles;
      send_slot(1'b1, 16'hFFFF, SLOT, 1'b0);
      expect_eq("no_valid_before_left", 32'(valid_cycles - v0), 32'd0);

      // 2: basic frame with ready high
      sample_ready = 1'b1;
      a0 = acc_cnt;
      v0 = valid_cycles;
      send_frame(16'h8001, 16'h7FFE, 1'b0);
      expect_eq("t2_accepts",  32'(acc_cnt - a0),      32'd1);
      expect_eq("t2_vcycles",  32'(valid_cycles - v0), 32'd1);
      expect_eq("t2_left",     32'(acc_l),             32'h8001);
      expect_eq("t2_right",    32'(acc_r),             32'h7FFE);
      expect_eq("t2_valid_lo", 32'(sample_valid),      32'h0);

      // 6: ready arrives in the very cycle the next frame completes
      sample_ready = 1'b0;
      send_frame(16'hA5A5, 16'h5A5A, 1'b0);
      expect_eq("t6_pending",  32'(sample_valid), 32'h1);
      expect_eq("t6_x_left",   32'(left_sample),  32'hA5A5);
      l0 = valid_low_cycles;
      a0 = acc_cnt;
      send_frame(16'hC3C3, 16'h3C3C, 1'b1);
      expect_eq("t6_no_gap",   32'(valid_low_cycles - l0), 32'd0);
      expect_eq("t6_valid",    32'(sample_valid),          32'h1);
      expect_eq("t6_y_left",   32'(left_sample),           32'hC3C3);
      expect_eq("t6_y_right",  32'(right_sample),          32'h3C3C);
      expect_eq("t6_overrun",  32'(overrun),               32'h0);
      expect_eq("t6_x_taken",  32'(acc_cnt - a0),          32'd1);
      expect_eq("t6_x_acc_l",  32'(acc_l),                 32'hA5A5);
      consume();
      expect_eq("t6_drained",  32'(sample_valid), 32'h0);
      expect_eq("t6_y_acc_r",  32'(acc_r),        32'h3C3C);

      // 3: overrun while the consumer stalls
      send_frame(16'h1234, 16'h5678, 1'b0);
      send_frame(16'h9ABC, 16'hDEF0, 1'b0);
      expect_eq("t3_valid",    32'(sample_valid), 32'h1);
      expect_eq("t3_left",     32'(left_sample),  32'h1234);
      expect_eq("t3_right",    32'(right_sample), 32'h5678);
      expect_eq("t3_overrun",  32'(overrun),      32'h1);
      consume();
      expect_eq("t3_acc_l",    32'(acc_l),        32'h1234);
      expect_eq("t3_acc_r",    32'(acc_r),        32'h5678);
      expect_eq("t3_drained",  32'(sample_valid), 32'h0);

      // 4: left cut short after 10 bits
      sample_ready = 1'b1;
      e0 = err_cycles;
      a0 = acc_cnt;
      send_slot(1'b0, 16'hAAAA, 12, 1'b0);
      send_slot(1'b1, 16'h5555, SLOT, 1'b0);
      expect_eq("t4_err_pulse",   32'(err_cycles - e0), 32'd1);
      expect_eq("t4_r_discarded", 32'(acc_cnt - a0),    32'd0);
      send_frame(16'h00FF, 16'hFF00, 1'b0);
      expect_eq("t4_accepts",  32'(acc_cnt - a0), 32'd1);
      expect_eq("t4_left",     32'(acc_l),        32'h00FF);
      expect_eq("t4_right",    32'(acc_r),        32'hFF00);
      expect_eq("t4_sticky",   32'(overrun),      32'h1);

      // 5: reset mid-left, then stimulus resumes mid right channel
      send_slot(1'b0, 16'hFFFF, 8, 1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      expect_eq("t5_rst_valid",   32'(sample_valid), 32'h0);
      expect_eq("t5_rst_overrun", 32'(overrun),      32'h0);
      expect_eq("t5_rst_left",    32'(left_sample),  32'h0);
      reset = 1'b1;
      a0 = acc_cnt;
      e0 = err_cycles;
      send_slot(1'b1, 16'hFFFF, 10, 1'b0);
      send_frame(16'h0F0F, 16'hF0F0, 1'b0);
      expect_eq("t5_accepts",  32'(acc_cnt - a0),    32'd1);
      expect_eq("t5_left",     32'(acc_l),           32'h0F0F);
      expect_eq("t5_right",    32'(acc_r),           32'hF0F0);
      expect_eq("t5_no_err",   32'(err_cycles - e0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
